// File: rtl/mdu_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package mdu_pkg;
   localparam int          WIDTH      = 16;
   localparam int          ADDR_W     = 4;
   localparam logic [15:0] DIV_ZERO_Q = 16'hFFFF;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the issue logic and the multiply/divide unit.
interface mdu_if #(
   parameter int WIDTH  = mdu_pkg::WIDTH,
   parameter int ADDR_W = mdu_pkg::ADDR_W
);
   logic                start;
   logic                op_div;
   logic                op_signed;
   logic [WIDTH-1:0]    opa;
   logic [WIDTH-1:0]    opb;
   logic [ADDR_W-1:0]   dest_addr;
   logic                busy;
   logic                done;
   logic [2*WIDTH-1:0]  result;
   logic                wr_en;
   logic                r0_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic                div_zero;

   modport master (
      output start, op_div, op_signed, opa, opb, dest_addr,
      input  busy, done, result, wr_en, r0_en, wr_addr, div_zero
   );

   modport slave (
      input  start, op_div, op_signed, opa, opb, dest_addr,
      output busy, done, result, wr_en, r0_en, wr_addr, div_zero
   );
endinterface

// File: rtl/mdu_sign_adj.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module mdu_sign_adj #(
   parameter int W = 16
) (
   input  logic [W-1:0] din,
   input  logic         neg,
   output logic [W-1:0] dout
);
   assign dout = neg ? (~din + 1'b1) : din;
endmodule

// File: rtl/mdu_seq.sv
// Iterative radix-2 multiply/divide unit feeding the register file write port.
// Works on magnitudes for WIDTH edges, then applies signs in a single FIX edge.
module mdu_seq #(
   parameter int WIDTH  = mdu_pkg::WIDTH,
   parameter int ADDR_W = mdu_pkg::ADDR_W,
   parameter int ITER   = WIDTH
) (
   input  logic  clockg,
   input  logic  rst,
   mdu_if.slave  bus
);
   import mdu_pkg::*;

   localparam int CNT_W = $clog2(ITER);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [WIDTH:0]       acc_q, acc_d;        // product high / partial remainder
   logic [WIDTH-1:0]     lo_q, lo_d;          // multiplier / dividend -> quotient
   logic [WIDTH-1:0]     op_q, op_d;          // multiplicand / divisor magnitude
   logic [WIDTH-1:0]     raw_a_q, raw_a_d;
   logic                 div_q, div_d;
   logic                 dz_q, dz_d;
   logic                 neg_quo_q, neg_quo_d;
   logic                 neg_rem_q, neg_rem_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 div_zero_q, div_zero_d;
   logic [2*WIDTH-1:0]   result_q, result_d;

   logic                 sa, sb;
   logic [WIDTH-1:0]     abs_a, abs_b;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_sh;
   logic [WIDTH+1:0]     div_trial;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   assign sa = bus.op_signed & bus.opa[WIDTH-1];
   assign sb = bus.op_signed & bus.opb[WIDTH-1];

   // |-2^(W-1)| stays representable because magnitudes are held unsigned.
   mdu_sign_adj #(.W(WIDTH)) u_abs_a (.din(bus.opa), .neg(sa), .dout(abs_a));
   mdu_sign_adj #(.W(WIDTH)) u_abs_b (.din(bus.opb), .neg(sb), .dout(abs_b));

   mdu_sign_adj #(.W(2*WIDTH)) u_fix_prod (
      .din({acc_q[WIDTH-1:0], lo_q}), .neg(neg_quo_q), .dout(prod_fix));
   mdu_sign_adj #(.W(WIDTH)) u_fix_quo (.din(lo_q), .neg(neg_quo_q), .dout(quo_fix));
   mdu_sign_adj #(.W(WIDTH)) u_fix_rem (
      .din(acc_q[WIDTH-1:0]), .neg(neg_rem_q), .dout(rem_fix));

   assign mul_sum   = acc_q + {1'b0, (lo_q[0] ? op_q : {WIDTH{1'b0}})};
   assign div_sh    = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
   // Extra top bit acts as the borrow of the restoring trial subtract.
   assign div_trial = {1'b0, div_sh} - {2'b00, op_q};

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      acc_d      = acc_q;
      lo_d       = lo_q;
      op_d       = op_q;
      raw_a_d    = raw_a_q;
      div_d      = div_q;
      dz_d       = dz_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      addr_d     = addr_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;
      result_d   = result_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               state_d    = CALC;
               count_d    = '0;
               acc_d      = '0;
               lo_d       = bus.op_div ? abs_a : abs_b;
               op_d       = bus.op_div ? abs_b : abs_a;
               raw_a_d    = bus.opa;
               div_d      = bus.op_div;
               dz_d       = (bus.opb == '0);
               neg_quo_d  = sa ^ sb;
               neg_rem_d  = sa;
               addr_d     = bus.dest_addr;
               busy_d     = 1'b1;
               div_zero_d = 1'b0;
            end
         end

         CALC: begin
            if (div_q) begin
               acc_d = div_trial[WIDTH+1] ? div_sh : div_trial[WIDTH:0];
               lo_d  = {lo_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
            end else begin
               acc_d = {1'b0, mul_sum[WIDTH:1]};
               lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            count_d = count_q + 1'b1;
            if (count_q == CNT_W'(ITER-1)) state_d = FIX;
         end

         FIX: begin
            if (!div_q)    result_d = prod_fix;
            else if (dz_q) result_d = {raw_a_q, WIDTH'(DIV_ZERO_Q)};
            else           result_d = {rem_fix, quo_fix};
            div_zero_d = div_q & dz_q;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = DONE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clockg or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         acc_q      <= '0;
         lo_q       <= '0;
         op_q       <= '0;
         raw_a_q    <= '0;
         div_q      <= 1'b0;
         dz_q       <= 1'b0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         addr_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         acc_q      <= acc_d;
         lo_q       <= lo_d;
         op_q       <= op_d;
         raw_a_q    <= raw_a_d;
         div_q      <= div_d;
         dz_q       <= dz_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         addr_q     <= addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         result_q   <= result_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.wr_en    = done_q;
   assign bus.r0_en    = done_q;
   assign bus.wr_addr  = addr_q;
   assign bus.div_zero = div_zero_q;
   assign bus.result   = result_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases plus random operations
// compared against an integer-arithmetic reference model.
module tb_mdu_seq;
   logic clockg = 1'b0;
   logic rst    = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   mdu_if bus ();

   mdu_seq dut (.clockg(clockg), .rst(rst), .bus(bus));

   always #5 clockg = ~clockg;

   // Reference: plain signed/unsigned integer arithmetic, C-style truncating division.
   function automatic logic [32:0] ref_calc(input logic div, input logic sgn,
                                            input logic [15:0] a, input logic [15:0] b);
      logic signed [63:0] pa, pb, r, q, m;
      pa = sgn ? 64'(signed'(a)) : 64'(a);
      pb = sgn ? 64'(signed'(b)) : 64'(b);
      if (!div) begin
         r = pa * pb;
         return {1'b0, r[31:0]};
      end
      if (b == 16'h0) return {1'b1, a, 16'hFFFF};
      q = pa / pb;
      m = pa % pb;
      return {1'b0, m[15:0], q[15:0]};
   endfunction

   task automatic do_op(input logic div, input logic sgn, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] addr,
                        output int lat, output logic [31:0] res, output logic dzf,
                        output logic [3:0] waddr, output logic wr_ok,
                        output logic busy_ok, output logic d0);
      @(negedge clockg);
      bus.op_div = div; bus.op_signed = sgn; bus.opa = a; bus.opb = b;
      bus.dest_addr = addr; bus.start = 1'b1;
      @(posedge clockg); #1;
      bus.start = 1'b0;
      d0 = bus.done;
      busy_ok = bus.busy;
      lat = -1; res = '0; dzf = 1'b0; waddr = '0; wr_ok = 1'b0;
      for (int n = 1; n <= 40 && lat < 0; n++) begin
         @(posedge clockg); #1;
         if (bus.done) begin
            lat = n; res = bus.result; dzf = bus.div_zero; waddr = bus.wr_addr;
            wr_ok = bus.wr_en & bus.r0_en;
            if (bus.busy) busy_ok = 1'b0;
         end else if (!bus.busy) busy_ok = 1'b0;
      end
   endtask

   task automatic test_reset;
      #1;
      n_tests++;
      if ({bus.busy, bus.done, bus.wr_en, bus.r0_en, bus.div_zero} !== 5'b0 ||
          bus.result !== 32'h0 || bus.wr_addr !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b result=%h, want all 0",
                  bus.busy, bus.done, bus.result);
      end
      repeat (2) @(posedge clockg);
      @(negedge clockg) rst = 1'b0;
      @(posedge clockg); #1;
      n_tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_mul;
      int lat; logic [31:0] res; logic dzf, wr_ok, bok, d0; logic [3:0] wa;
      do_op(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 4'd3, lat, res, dzf, wa, wr_ok, bok, d0);
      n_tests++;
      if (lat !== 17) begin n_fail++; $display("FAIL mul_latency: got %0d want 17", lat); end
      n_tests++;
      if (res !== 32'hFFFE0001) begin n_fail++; $display("FAIL mul_uu: got %h want fffe0001", res); end
      n_tests++;
      if (wr_ok !== 1'b1 || bok !== 1'b1) begin
         n_fail++; $display("FAIL mul_wr_busy: got wr=%b busy_ok=%b want 1 1", wr_ok, bok);
      end
      @(posedge clockg); #1;
      n_tests++;
      if ({bus.done, bus.wr_en, bus.r0_en, bus.busy} !== 4'b0) begin
         n_fail++;
         $display("FAIL mul_pulse: got done/wr/r0/busy=%b%b%b%b want 0000",
                  bus.done, bus.wr_en, bus.r0_en, bus.busy);
      end
      n_tests++;
      if (bus.result !== 32'hFFFE0001) begin
         n_fail++; $display("FAIL mul_hold: got %h want fffe0001", bus.result);
      end
      do_op(1'b0, 1'b1, 16'hFFFE, 16'h0003, 4'd1, lat, res, dzf, wa, wr_ok, bok, d0);
      n_tests++;
      if (res !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mul_ss_neg: got %h want fffffffa", res); end
      do_op(1'b0, 1'b1, 16'h8000, 16'h8000, 4'd1, lat, res, dzf, wa, wr_ok, bok, d0);
      n_tests++;
      if (res !== 32'h40000000) begin n_fail++; $display("FAIL mul_ss_min: got %h want 40000000", res); end
   endtask

   task automatic test_div;
      int lat; logic [31:0] res; logic dzf, wr_ok, bok, d0; logic [3:0] wa;
      do_op(1'b1, 1'b0, 16'd100, 16'd7, 4'd5, lat, res, dzf, wa, wr_ok, bok, d0);
      n_tests++;
      if (res !== 32'h0002000E) begin n_fail++; $display("FAIL div_uu: got %h want 0002000e", res); end
      n_tests++;
      if (wa !== 4'd5 || dzf !== 1'b0 || lat !== 17) begin
         n_fail++; $display("FAIL div_addr_flag: got addr=%0d dz=%b lat=%0d want 5 0 17", wa, dzf, lat);
      end
      do_op(1'b1, 1'b1, 16'hFFF9, 16'h0002, 4'd2, lat, res, dzf, wa, wr_ok, bok, d0);
      n_tests++;
      if (res !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_ss_neg: got %h want fffffffd", res); end
      do_op(1'b1, 1'b1, 16'h8000, 16'hFFFF, 4'd2, lat, res, dzf, wa, wr_ok, bok, d0);
      n_tests++;
      if (res !== 32'h00008000 || dzf !== 1'b0) begin
         n_fail++; $display("FAIL div_min_m1: got %h dz=%b want 00008000 0", res, dzf);
      end
   endtask

   task automatic test_div_zero;
      int lat; logic [31:0] res; logic dzf, wr_ok, bok, d0; logic [3:0] wa;
      do_op(1'b1, 1'b1, 16'h1234, 16'h0000, 4'd7, lat, res, dzf, wa, wr_ok, bok, d0);
      n_tests++;
      if (lat !== 17 || res !== 32'h1234FFFF || dzf !== 1'b1) begin
         n_fail++; $display("FAIL div_zero: got lat=%0d res=%h dz=%b want 17 1234ffff 1", lat, res, dzf);
      end
      @(posedge clockg); #1;
      n_tests++;
      if (bus.div_zero !== 1'b1) begin n_fail++; $display("FAIL div_zero_hold: got %b want 1", bus.div_zero); end
      do_op(1'b0, 1'b0, 16'd2, 16'd3, 4'd7, lat, res, dzf, wa, wr_ok, bok, d0);
      n_tests++;
      if (dzf !== 1'b0 || res !== 32'd6) begin
         n_fail++; $display("FAIL div_zero_clear: got dz=%b res=%h want 0 00000006", dzf, res);
      end
   endtask

   task automatic test_back_to_back;
      int lat; logic [31:0] res; logic dzf, wr_ok, bok, d0; logic [3:0] wa;
      do_op(1'b0, 1'b0, 16'd300, 16'd5, 4'd4, lat, res, dzf, wa, wr_ok, bok, d0);
      do_op(1'b1, 1'b0, 16'd1000, 16'd33, 4'd9, lat, res, dzf, wa, wr_ok, bok, d0);
      n_tests++;
      if (d0 !== 1'b0 || bok !== 1'b1) begin
         n_fail++; $display("FAIL b2b_handover: got done=%b busy_ok=%b want 0 1", d0, bok);
      end
      n_tests++;
      if (lat !== 17 || res !== {16'd10, 16'd30} || wa !== 4'd9) begin
         n_fail++; $display("FAIL b2b_result: got lat=%0d res=%h addr=%0d want 17 000a001e 9", lat, res, wa);
      end
   endtask

   task automatic test_start_ignore;
      int lat;
      @(negedge clockg);
      bus.op_div = 1'b0; bus.op_signed = 1'b0; bus.opa = 16'd1234; bus.opb = 16'd10;
      bus.dest_addr = 4'd6; bus.start = 1'b1;
      @(posedge clockg); #1 bus.start = 1'b0;
      repeat (4) @(posedge clockg);
      @(negedge clockg);
      bus.op_div = 1'b1; bus.opa = 16'd77; bus.opb = 16'd3; bus.dest_addr = 4'd2; bus.start = 1'b1;
      @(posedge clockg); #1 bus.start = 1'b0;
      lat = -1;
      for (int n = 6; n <= 40 && lat < 0; n++) begin
         @(posedge clockg); #1;
         if (bus.done) lat = n;
      end
      n_tests++;
      if (lat !== 17 || bus.result !== 32'd12340 || bus.wr_addr !== 4'd6) begin
         n_fail++;
         $display("FAIL start_ignore: got lat=%0d res=%h addr=%0d want 17 00003034 6",
                  lat, bus.result, bus.wr_addr);
      end
   endtask

   task automatic test_reset_mid;
      int wr_seen;
      logic pre_busy;
      @(negedge clockg);
      bus.op_div = 1'b1; bus.op_signed = 1'b0; bus.opa = 16'd500; bus.opb = 16'd9;
      bus.dest_addr = 4'd8; bus.start = 1'b1;
      @(posedge clockg); #1 bus.start = 1'b0;
      repeat (8) @(posedge clockg);
      pre_busy = bus.busy;
      #1 rst = 1'b1;
      #1;
      n_tests++;
      if (pre_busy !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid: got pre_busy=%b busy=%b done=%b res=%h want 1 0 0 0",
                  pre_busy, bus.busy, bus.done, bus.result);
      end
      repeat (2) @(posedge clockg);
      @(negedge clockg) rst = 1'b0;
      wr_seen = 0;
      for (int n = 0; n < 25; n++) begin
         @(posedge clockg); #1;
         if (bus.done || bus.wr_en || bus.r0_en) wr_seen++;
      end
      n_tests++;
      if (wr_seen !== 0) begin n_fail++; $display("FAIL reset_no_write: got %0d pulses want 0", wr_seen); end
   endtask

   task automatic test_random;
      int lat; logic [31:0] res; logic dzf, wr_ok, bok, d0; logic [3:0] wa;
      logic div, sgn; logic [15:0] a, b; logic [3:0] addr; logic [32:0] exp;
      for (int i = 0; i < 40; i++) begin
         div  = 1'($urandom_range(0, 1));
         sgn  = 1'($urandom_range(0, 1));
         a    = 16'($urandom);
         b    = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
         if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 20));
         addr = 4'($urandom);
         exp  = ref_calc(div, sgn, a, b);
         do_op(div, sgn, a, b, addr, lat, res, dzf, wa, wr_ok, bok, d0);
         n_tests++;
         if (lat !== 17 || res !== exp[31:0] || dzf !== exp[32] || wa !== addr) begin
            n_fail++;
            $display("FAIL random[%0d] div=%b sgn=%b a=%h b=%h: got lat=%0d res=%h dz=%b addr=%0d want 17 %h %b %0d",
                     i, div, sgn, a, b, lat, res, dzf, wa, exp[31:0], exp[32], addr);
         end
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.op_div = 1'b0; bus.op_signed = 1'b0;
      bus.opa = '0; bus.opb = '0; bus.dest_addr = '0;
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_back_to_back();
      test_start_ignore();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Sequential multiply/divide unit in the execute stage, directly upstream of the register file write port.
- Produces a 32-bit result word. Bits [31:16] are the upper half (product high or remainder) and go to R0. Bits [15:0] (product low or quotient) go to the destination register.
- Drives the register file's write_data, write_en, R0_en and write_address directly.
- Iterative radix-2 datapath: 16 iterations plus 1 correction cycle.

Parameters:
- WIDTH, 16, operand width; result is 2*WIDTH.
- ADDR_W, 4, destination register address width.
- ITER, WIDTH, iteration count; must equal WIDTH.

Ports:
- clockg  in  1  clock (gated system clock)
- rst  in  1  reset
- start  in  1  request; sampled only in IDLE or DONE
- op_div  in  1  0 = multiply, 1 = divide
- op_signed  in  1  1 = two's-complement operands
- opa  in  WIDTH  multiplicand / dividend
- opb  in  WIDTH  multiplier / divisor
- dest_addr  in  ADDR_W  destination register, captured at start
- busy  out  1  high in CALC and FIX; pipeline stalls on it
- done  out  1  one-cycle completion pulse
- result  out  2*WIDTH  {upper, lower}; held until next accepted start
- wr_en  out  1  equals done
- r0_en  out  1  equals done
- wr_addr  out  ADDR_W  captured dest_addr
- div_zero  out  1  set with done when a divide has opb == 0; held with result

Behaviour:
- Reset rst is asynchronous, active-high; clock is clockg. Reset drives state to IDLE, all outputs 0, internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start:
  - Capture op_div, op_signed, dest_addr.
  - Load |opa| and |opb| (raw values when unsigned).
  - Latch the sign flags: neg_q = sa^sb; neg_r = sa.
  - Clear the accumulator; set count = 0; go to CALC.
- DONE without start -> IDLE.
- CALC: one iteration per edge; on count == ITER-1 go to FIX.
  - Multiply: shift-add; if multiplier LSB is 1, add multiplicand to the accumulator upper half; shift right {acc, mplr} by 1.
  - Divide: restoring; shift {rem, quo} left 1; trial = rem - divisor; if non-negative then rem = trial and quo LSB = 1.
- FIX (1 edge), then go to DONE:
  - Multiply: negate the 32-bit product if neg_q.
  - Divide: negate quotient if neg_q; negate remainder if neg_r.
  - Write result; set done, wr_en, r0_en.
- DONE: done/wr_en/r0_en = 1 for exactly this cycle.
- Timing:
  - start sampled at edge 0.
  - CALC occupies edges 1..16; FIX at edge 17.
  - done high from edge 17 to edge 18; busy high from edge 0 to edge 17.
- Back-to-back: start asserted during DONE is accepted. done still drops at the next edge and busy rises at that edge.
- start during CALC/FIX: ignored; operands are not re-sampled.
- Divide by zero:
  - Same latency as a normal divide; div_zero = 1.
  - result = {opa, 16'hFFFF}, raw opa regardless of op_signed.
- Signed -32768 / -1: quotient wraps to 16'h8000, remainder 0, no flag.
- Signed -32768 * -32768 = 32'h40000000; the |x| datapath must hold 16-bit magnitude 0x8000 unsigned.
- div_zero clears on the next accepted start.
- Reset mid-operation: immediate return to IDLE. The partial result is discarded, and no done pulse or write occurs.
- Arithmetic: divide remainder register is WIDTH+1 bits for the trial subtract. Accumulator is WIDTH+1 bits for the multiply carry.

Decomposition:
- Package mdu_pkg:
  - typedef enum state_t {IDLE, CALC, FIX, DONE}
  - constants WIDTH = 16, ADDR_W = 4
  - localparam DIV_ZERO_Q = 16'hFFFF
- Sub-module mdu_sign_adj: combinational conditional two's-complement negate, parameterised width. Instantiated for operand abs-value (16-bit) and for result fix (16/32-bit).
- FSM, counter and shift datapath stay in mdu_seq.

Test Plan:
- Unsigned multiply 0xFFFF * 0xFFFF, start at edge 0.
  -> done at edge 17; result = 0xFFFE0001; wr_en = r0_en = 1 for exactly one cycle; busy low after edge 17.
- Signed multiply 0xFFFE * 0x0003.
  -> result = 0xFFFFFFFA; signed multiply 0x8000 * 0x8000 -> 0x40000000.
- Unsigned divide 100 / 7, dest_addr = 5.
  -> result = 0x0002000E; wr_addr = 5; div_zero = 0.
- Signed divide 0xFFF9 / 0x0002 (-7 / 2).
  -> result = 0xFFFFFFFD (rem -1, quo -3); then 0x8000 / 0xFFFF -> 0x00008000.
- Divide 0x1234 / 0.
  -> done at edge 17; result = 0x1234FFFF; div_zero = 1; next multiply clears div_zero.
- Reset and start-ignore:
  - Assert rst at edge 8 of a divide -> busy = done = 0 and result = 0 immediately; no write pulse follows.
  - start pulsed during CALC -> ignored; original operands' result delivered.
